// File: rtl/alu_iter_comparator.sv
// Multi-cycle MSB-first magnitude comparator with valid/ready on both sides.
// Signed compares are reduced to unsigned by flipping the sign bit at capture.
module alu_iter_comparator #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  Greater,
  output logic                  Equal,
  output logic                  Less,
  output logic                  busy
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0] r_a, r_b;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_gt, r_eq, r_lt;

  logic [DATA_WIDTH-1:0] w_a_bias, w_b_bias;
  logic [NUM_CHUNKS-1:0] w_ch_gt, w_ch_lt;
  logic                  w_gt, w_lt, w_ne;
  logic                  w_accept, w_release, w_last;

  // Offset-binary bias: flipping the sign bit orders two's-complement values
  // the same way as unsigned ones.
  assign w_a_bias = {operand_A[DATA_WIDTH-1] ^ is_signed, operand_A[DATA_WIDTH-2:0]};
  assign w_b_bias = {operand_B[DATA_WIDTH-1] ^ is_signed, operand_B[DATA_WIDTH-2:0]};

  generate
    for (genvar c = 0; c < NUM_CHUNKS; c++) begin : g_chunk
      assign w_ch_gt[c] = r_a[c*CHUNK_WIDTH +: CHUNK_WIDTH] > r_b[c*CHUNK_WIDTH +: CHUNK_WIDTH];
      assign w_ch_lt[c] = r_a[c*CHUNK_WIDTH +: CHUNK_WIDTH] < r_b[c*CHUNK_WIDTH +: CHUNK_WIDTH];
    end
    if (NUM_CHUNKS == 1) begin : g_sel_one
      assign w_gt   = w_ch_gt[0];
      assign w_lt   = w_ch_lt[0];
      assign w_last = 1'b1;
    end else begin : g_sel_many
      assign w_gt   = w_ch_gt[r_idx];
      assign w_lt   = w_ch_lt[r_idx];
      assign w_last = (r_idx == '0);
    end
  endgenerate

  assign w_ne      = w_gt | w_lt;
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = in_valid & in_ready;
  assign w_release = out_valid & out_ready;

  assign Greater = r_gt;
  assign Equal   = r_eq;
  assign Less    = r_lt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept)          w_next = S_COMPARE;
      S_COMPARE: if (w_ne || w_last)    w_next = S_DONE;
      S_DONE:    if (w_release)         w_next = S_IDLE;
      default:                          w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= IDX_TOP;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= w_a_bias;
            r_b   <= w_b_bias;
            r_idx <= IDX_TOP;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
          end
        end
        S_COMPARE: begin
          if (w_ne) begin
            r_gt <= w_gt;
            r_lt <= w_lt;
            r_eq <= 1'b0;
          end else if (w_last) begin
            r_eq <= 1'b1;
            r_gt <= 1'b0;
            r_lt <= 1'b0;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        S_DONE: begin
          // Flags stay put after release until the next capture.
          if (w_release) r_idx <= IDX_TOP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_comparator.sv
// Scoreboard bench for alu_iter_comparator: default 8-bit chunks plus a
// single-chunk instance.
module tb_alu_iter_comparator;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NC = DW / CW;

  logic clk, rst_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] operand_A, operand_B;
  logic is_signed, Greater, Equal, Less, busy;

  logic in_valid1, in_ready1, out_valid1, out_ready1;
  logic [DW-1:0] operand_A1, operand_B1;
  logic is_signed1, Greater1, Equal1, Less1, busy1;

  int checks = 0;
  int errors = 0;

  logic [2:0] q_flags[$];
  int         q_lat[$];
  logic [2:0] q1_flags[$];

  alu_iter_comparator #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand_A(operand_A), .operand_B(operand_B), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .Greater(Greater), .Equal(Equal), .Less(Less), .busy(busy)
  );

  alu_iter_comparator #(.DATA_WIDTH(DW), .CHUNK_WIDTH(DW)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .operand_A(operand_A1), .operand_B(operand_B1), .is_signed(is_signed1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .Greater(Greater1), .Equal(Equal1), .Less(Less1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_cmp(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic s);
    if (a == b) return 3'b010;
    if (s) return ($signed(a) > $signed(b)) ? 3'b100 : 3'b001;
    return (a > b) ? 3'b100 : 3'b001;
  endfunction

  function automatic int ref_lat(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int c = NC - 1; c >= 0; c--)
      if (a[c*CW +: CW] != b[c*CW +: CW]) return NC - c;
    return NC;
  endfunction

  // One transaction on the default instance; hold = cycles of backpressure.
  task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                         input int hold, input string name, output int busy_cnt);
    int cyc;
    logic [2:0] exp_f, obs_f;
    int exp_l;
    q_flags.push_back(ref_cmp(a, b, s));
    q_lat.push_back(ref_lat(a, b));
    busy_cnt = 0;
    @(negedge clk);
    operand_A = a; operand_B = b; is_signed = s; in_valid = 1'b1;
    out_ready = (hold == 0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready_idle got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    do begin
      busy_cnt += int'(busy);
      @(posedge clk); #1;
      cyc++;
    end while (out_valid !== 1'b1 && cyc < 40);
    exp_f = q_flags.pop_front();
    exp_l = q_lat.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s timeout out_valid got %b want 1", name, out_valid);
      out_ready = 1'b1;
      return;
    end
    if (cyc != exp_l) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, cyc, exp_l);
    end
    obs_f = {Greater, Equal, Less};
    checks++;
    if (obs_f !== exp_f) begin
      errors++; $display("FAIL %s flags got %b want %b", name, obs_f, exp_f);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1; operand_A = ~a; operand_B = a; is_signed = ~s;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, busy, in_ready, Greater, Equal, Less} !== {3'b110, exp_f}) begin
        errors++;
        $display("FAIL %s hold%0d v/b/r/flags got %b%b%b %b want 110 %b", name, h,
                 out_valid, busy, in_ready, {Greater, Equal, Less}, exp_f);
      end
    end
    busy_cnt += int'(busy);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || {Greater, Equal, Less} !== exp_f) begin
      errors++;
      $display("FAIL %s release r/v/b got %b%b%b flags %b want 100 flags %b", name,
               in_ready, out_valid, busy, {Greater, Equal, Less}, exp_f);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; operand_A = '0; operand_B = '0; is_signed = 0;
    in_valid1 = 0; out_ready1 = 1; operand_A1 = '0; operand_B1 = '0; is_signed1 = 0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, Greater, Equal, Less} !== 6'b100000) begin
      errors++; $display("FAIL reset outputs got %b want 100000",
                         {in_ready, out_valid, busy, Greater, Equal, Less});
    end
    checks++;
    if ({in_ready1, out_valid1, busy1} !== 3'b100) begin
      errors++; $display("FAIL reset1 outputs got %b want 100", {in_ready1, out_valid1, busy1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_sign_split();
    int bc;
    run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, "split_s", bc);
    run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "split_u", bc);
    run_txn(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, "ext_s", bc);
    run_txn(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, "ext_u", bc);
    run_txn(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0, "ext_s_rev", bc);
  endtask

  task automatic test_equal();
    int bc;
    run_txn(32'h1234_5678, 32'h1234_5678, 1'b0, 0, "equal", bc);
    checks++;
    if (bc != NC + 1) begin
      errors++; $display("FAIL equal busy_cycles got %0d want %0d", bc, NC + 1);
    end
    run_txn(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "equal_s", bc);
  endtask

  task automatic test_lsb_chunk();
    int bc;
    run_txn(32'h0000_0005, 32'h0000_0003, 1'b1, 0, "lsb_gt", bc);
    run_txn(32'h1234_5600, 32'h1234_56FF, 1'b0, 0, "lsb_lt", bc);
    run_txn(32'hABCD_0000, 32'hABCE_0000, 1'b1, 0, "chunk1", bc);
  endtask

  task automatic test_backpressure();
    int bc;
    run_txn(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 3, "bp_lt", bc);
    run_txn(32'h0101_0101, 32'h0101_0101, 1'b0, 3, "bp_eq", bc);
  endtask

  task automatic test_reset_mid();
    int bc;
    @(negedge clk);
    operand_A = 32'hAAAA_AAAA; operand_B = 32'hAAAA_AAAA; is_signed = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, Greater, Equal, Less} !== 6'b100000) begin
      errors++; $display("FAIL rst_mid outputs got %b want 100000",
                         {in_ready, out_valid, busy, Greater, Equal, Less});
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin @(negedge clk); rst_n = 1'b1; end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_mid_drop cyc%0d valid/busy got %b%b want 00", i, out_valid, busy);
      end
    end
    run_txn(32'h0000_0001, 32'h0000_0002, 1'b0, 0, "after_rst", bc);
  endtask

  task automatic test_random();
    int bc;
    logic [DW-1:0] a, b, m;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      m = 32'hFF << (8 * (i % NC));
      b = a ^ ($urandom & m);
      run_txn(a, b, 1'(i & 1), (i % 5 == 0) ? 1 : 0, "rand", bc);
    end
  endtask

  task automatic test_single_cycle();
    logic [DW-1:0] ta[6];
    logic [DW-1:0] tb[6];
    logic [2:0] exp_f;
    ta = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'hAAAA_AAAA, 32'h0000_0005};
    tb = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0002, 32'hAAAA_AAAA, 32'h0000_0003};
    for (int i = 0; i < 6; i++) begin
      q1_flags.push_back(ref_cmp(ta[i], tb[i], 1'(i % 2)));
      @(negedge clk);
      operand_A1 = ta[i]; operand_B1 = tb[i]; is_signed1 = 1'(i % 2); in_valid1 = 1'b1;
      @(posedge clk); #1 in_valid1 = 1'b0;
      @(posedge clk); #1;
      exp_f = q1_flags.pop_front();
      checks++;
      if (out_valid1 !== 1'b1 || {Greater1, Equal1, Less1} !== exp_f) begin
        errors++; $display("FAIL single%0d valid/flags got %b %b want 1 %b", i,
                           out_valid1, {Greater1, Equal1, Less1}, exp_f);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_sign_split();
    test_equal();
    test_lsb_chunk();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_single_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
